// File: rtl/adder_i4_o3_wce2_pkg.sv
// Shared widths, defaults and request/response types for the approximate 2-bit adder.
package adder_i4_o3_wce2_pkg;

    localparam int OPND_W        = 2;   // operand width
    localparam int SUM_W         = 3;   // exact/approximate sum width
    localparam int ERR_W         = 2;   // error magnitude width
    localparam int WCE_BOUND_DEF = 2;   // default error-flag threshold
    localparam int STAGES        = 1;   // input-to-output latency in cycles

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } add_req_t;

    typedef struct packed {
        logic [SUM_W-1:0] approx;
        logic [SUM_W-1:0] exact;
        logic [ERR_W-1:0] err;
    } add_rsp_t;

endpackage

// File: rtl/adder_i4_o3_wce2_core.sv
// Combinational core: approximate sum (LSB carry dropped), exact sum and |exact - approx|.
module adder_i4_o3_wce2_core
    import adder_i4_o3_wce2_pkg::*;
(
    input  add_req_t req,
    output add_rsp_t rsp
);

    // Bit-level approximate sum, exact reference and their absolute difference.
    always_comb begin
        rsp        = '0;
        rsp.approx = {req.a[1] & req.b[1],
                      req.a[1] ^ req.b[1],
                      req.a[0] | req.b[0]};
        rsp.exact  = SUM_W'(req.a) + SUM_W'(req.b);
        // True difference never exceeds 1, so low-bit subtraction is exact.
        if (rsp.exact >= rsp.approx)
            rsp.err = rsp.exact[ERR_W-1:0] - rsp.approx[ERR_W-1:0];
        else
            rsp.err = rsp.approx[ERR_W-1:0] - rsp.exact[ERR_W-1:0];
    end

endmodule

// File: rtl/adder_i4_o3_wce2.sv
// Top: operand packing, result registers and the valid pipeline around the combinational core.
module adder_i4_o3_wce2
    import adder_i4_o3_wce2_pkg::*;
#(
    parameter int WCE_BOUND = WCE_BOUND_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pi0,
    input  logic             pi1,
    input  logic             pi2,
    input  logic             pi3,
    input  logic             in_valid,
    output logic             po0,
    output logic             po1,
    output logic             po2,
    output logic             out_valid,
    output logic [SUM_W-1:0] exact_sum,
    output logic [ERR_W-1:0] err_mag,
    output logic             wce_viol
);

    add_req_t          req;
    add_rsp_t          rsp;
    add_rsp_t          rsp_q;
    logic              viol_d;
    logic              viol_q;
    logic [STAGES-1:0] vld_q;
    logic [STAGES:0]   vld_pipe;

    assign req.a = {pi1, pi0};
    assign req.b = {pi3, pi2};

    adder_i4_o3_wce2_core u_core (
        .req (req),
        .rsp (rsp)
    );

    // Threshold compare on the unregistered error so the flag lines up with err_mag.
    always_comb begin
        viol_d = (int'(rsp.err) > WCE_BOUND);
    end

    // Valid pipeline: tap 0 is the live input, upper taps are registered stages.
    always_comb begin
        vld_pipe = {vld_q, in_valid};
    end

    // Shift valid; reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_pipe[STAGES-1:0];
    end

    // Result registers load on valid input and hold otherwise; reset wins over in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q  <= '0;
            viol_q <= 1'b0;
        end else if (in_valid) begin
            rsp_q  <= rsp;
            viol_q <= viol_d;
        end
    end

    assign {po2, po1, po0} = rsp_q.approx;
    assign exact_sum       = rsp_q.exact;
    assign err_mag         = rsp_q.err;
    assign wce_viol        = viol_q;
    assign out_valid       = vld_pipe[STAGES];

endmodule

// File: tb/tb_adder_i4_o3_wce2.sv
// Scoreboard bench for the approximate 2-bit adder.
module tb_adder_i4_o3_wce2;

    localparam int WCE_BOUND = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pi0 = 1'b0, pi1 = 1'b0, pi2 = 1'b0, pi3 = 1'b0;
    logic       in_valid = 1'b0;
    logic       po0, po1, po2, out_valid, wce_viol;
    logic [2:0] exact_sum;
    logic [1:0] err_mag;

    // {approx[2:0], exact[2:0], err[1:0], viol}
    logic [8:0] sb_q[$];
    logic [8:0] last_res;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         max_err  = 0;

    adder_i4_o3_wce2 #(.WCE_BOUND(WCE_BOUND)) dut (
        .clk(clk), .rst(rst),
        .pi0(pi0), .pi1(pi1), .pi2(pi2), .pi3(pi3),
        .in_valid(in_valid),
        .po0(po0), .po1(po1), .po2(po2),
        .out_valid(out_valid), .exact_sum(exact_sum),
        .err_mag(err_mag), .wce_viol(wce_viol)
    );

    always #5 clk = ~clk;

    // Reference: exact sum from integer add; error is the dropped LSB carry.
    function automatic logic [8:0] model(input logic [3:0] p);
        int a, b, ex, er, ap;
        a  = int'(p[1:0]);
        b  = int'(p[3:2]);
        ex = a + b;
        er = (p[0] && p[2]) ? 1 : 0;
        ap = ex - er;
        return {3'(ap), 3'(ex), 2'(er), (er > WCE_BOUND)};
    endfunction

    function automatic logic [9:0] observed();
        return {out_valid, po2, po1, po0, exact_sum, err_mag, wce_viol};
    endfunction

    // Drive one cycle, push expectation if the input should be accepted, sample 1 after the edge.
    task automatic drive(input logic [3:0] p, input logic v, input logic r);
        {pi3, pi2, pi1, pi0} = p;
        in_valid = v;
        rst      = r;
        if (v && !r) sb_q.push_back(model(p));
        if (r) sb_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp(output logic [8:0] e);
        if (sb_q.size() == 0) begin
            e = 'x;
        end else begin
            e = sb_q.pop_front();
            last_res = e;
        end
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        for (int i = 0; i < 2; i++) begin
            drive(4'b1111, 1'b1, 1'b1);
            obs = observed();
            n_checks++;
            if (obs !== 10'b0) $display("FAIL reset_%0d got=%b want=%b", i, obs, 10'b0);
            else n_pass++;
        end
        last_res = '0;
    endtask

    task automatic test_directed();
        logic [3:0] vec [4] = '{4'b0000, 4'b0101, 4'b1111, 4'b1010};
        logic [8:0] want [4] = '{9'b000_000_00_0, 9'b001_010_01_0,
                                 9'b101_110_01_0, 9'b100_100_00_0};
        logic [8:0] e;
        logic [9:0] obs;
        for (int i = 0; i < 4; i++) begin
            drive(vec[i], 1'b1, 1'b0);
            pop_exp(e);
            obs = observed();
            n_checks++;
            if (obs !== {1'b1, want[i]} || e !== want[i])
                $display("FAIL directed_%b got=%b want=%b model=%b", vec[i], obs, {1'b1, want[i]}, e);
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        logic [9:0] obs;
        for (int i = 0; i < 2; i++) begin
            drive(4'(i + 5), 1'b0, 1'b0);
            obs = observed();
            n_checks++;
            if (obs !== {1'b0, last_res}) $display("FAIL hold_%0d got=%b want=%b", i, obs, {1'b0, last_res});
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] e;
        logic [9:0] obs;
        max_err = 0;
        for (int i = 0; i < 16; i++) begin
            drive(4'(i), 1'b1, 1'b0);
            pop_exp(e);
            obs = observed();
            if (int'(err_mag) > max_err) max_err = int'(err_mag);
            n_checks++;
            if (obs !== {1'b1, e}) $display("FAIL sweep_%0d got=%b want=%b", i, obs, {1'b1, e});
            else n_pass++;
        end
        n_checks++;
        if (max_err !== 1) $display("FAIL sweep_max_err got=%0d want=1", max_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [8:0] e;
        logic [9:0] obs;
        for (int i = 0; i < 10; i++) begin
            drive(4'(15 - i), 1'b1, (i == 5));
            obs = observed();
            n_checks++;
            if (i == 5) begin
                if (obs !== 10'b0) $display("FAIL midreset got=%b want=%b", obs, 10'b0);
                else n_pass++;
            end else begin
                pop_exp(e);
                if (obs !== {1'b1, e}) $display("FAIL midsweep_%0d got=%b want=%b", i, obs, {1'b1, e});
                else n_pass++;
            end
        end
        // Idle after the burst: valid drops, results hold.
        drive(4'b0000, 1'b0, 1'b0);
        obs = observed();
        n_checks++;
        if (obs !== {1'b0, last_res}) $display("FAIL idle_after got=%b want=%b", obs, {1'b0, last_res});
        else n_pass++;
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_left got=%0d want=0", sb_q.size());
        else n_pass++;
    endtask

    initial begin
        last_res = '0;
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
